// File: rtl/sum_buf_pkg.sv
// Shared sizing for the nibble-adder result buffer.
// Default widths and derived pointer/counter widths.
package sum_buf_pkg;
  localparam int DATA_W = 5;
  localparam int DEPTH  = 4;
  localparam int ACC_W  = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
endpackage

// File: rtl/sum_fifo_ctrl.sv
// Pointer/occupancy control for the result FIFO.
// Qualifies push/pop and flags dropped samples.
module sum_fifo_ctrl #(
  parameter int DEPTH = sum_buf_pkg::DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             push,
  output logic             pop,
  output logic             drop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  // Occupancy flags and handshake qualification
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    pop   = ena & ~empty & out_ready;
    push  = ena & in_valid & (~full | pop);
    drop  = ena & in_valid & full & ~pop;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy moves only when exactly one side fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sum_result_buffer.sv
// Result buffer behind the nibble adder: FIFO of results
// plus a running modulo accumulator and sticky overflow.
module sum_result_buffer #(
  parameter int DATA_W = sum_buf_pkg::DATA_W,
  parameter int DEPTH  = sum_buf_pkg::DEPTH,
  parameter int ACC_W  = sum_buf_pkg::ACC_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [ACC_W-1:0]  acc,
  input  logic              acc_clr
);

  logic              push;
  logic              pop;
  logic              drop;
  logic              clr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ACC_W-1:0]  in_ext;
  logic [DATA_W-1:0] mem [DEPTH];

  sum_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .push      (push),
    .pop       (pop),
    .drop      (drop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Fall-through head, zero when empty; clear gated by ena
  always_comb begin
    out_valid = ~empty;
    out_data  = empty ? '0 : mem[rd_ptr];
    clr       = ena & acc_clr;
    in_ext    = ACC_W'(in_data);
  end

  // Storage is not reset; only written on an accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Accumulator: clear wins, but a coincident push seeds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= push ? in_ext : '0;
    end else if (push) begin
      acc <= acc + in_ext;
    end
  end

  // Sticky overflow: a drop beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_result_buffer.sv
// Directed bench for sum_result_buffer with a
// scoreboard queue and a small reference model.
module tb_sum_result_buffer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [4:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] acc;
  logic       acc_clr;

  int checks = 0;
  int errors = 0;

  logic [4:0] q[$];
  int         mcount;
  logic [7:0] macc;
  logic       movf;

  sum_result_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .acc       (acc),
    .acc_clr   (acc_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mcount = 0;
    macc   = 8'h00;
    movf   = 1'b0;
  endtask

  // One clock: drive at negedge, check head, predict, check state
  task automatic step(input bit en, input bit iv,
                      input logic [4:0] d,
                      input bit ordy, input bit clr);
    bit mpop;
    bit mpush;
    bit mdrop;
    @(negedge clk);
    ena       = en;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    acc_clr   = clr;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mcount != 0});
    if (mcount != 0) chk("head", {27'd0, out_data}, {27'd0, q[0]});
    else chk("out_data_empty", {27'd0, out_data}, 32'd0);
    mpop  = en && (mcount != 0) && ordy;
    mpush = en && iv && ((mcount < 4) || mpop);
    mdrop = en && iv && (mcount == 4) && !mpop;
    if (mpop) void'(q.pop_front());
    if (mpush) q.push_back(d);
    if (mpush && !mpop) mcount++;
    if (mpop && !mpush) mcount--;
    if (en && clr) macc = mpush ? {3'b000, d} : 8'h00;
    else if (mpush) macc = macc + {3'b000, d};
    if (mdrop) movf = 1'b1;
    else if (en && clr) movf = 1'b0;
    @(posedge clk);
    #1;
    chk("count", {29'd0, count}, mcount);
    chk("acc", {24'd0, acc}, {24'd0, macc});
    chk("overflow", {31'd0, overflow}, {31'd0, movf});
    chk("full", {31'd0, full}, {31'd0, mcount == 4});
    chk("empty", {31'd0, empty}, {31'd0, mcount == 0});
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 5'h00;
    out_ready = 1'b0;
    acc_clr   = 1'b0;
    model_reset();
    #12;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {27'd0, out_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_acc", {24'd0, acc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three pushes held, then drained in order
    step(1, 1, 5'h03, 0, 0);
    step(1, 1, 5'h1F, 0, 0);
    step(1, 1, 5'h08, 0, 0);
    chk("t2_count", {29'd0, count}, 32'd3);
    chk("t2_head", {27'd0, out_data}, 32'h03);
    chk("t2_acc", {24'd0, acc}, 32'h2A);
    step(1, 0, 5'h00, 1, 0);
    step(1, 0, 5'h00, 1, 0);
    step(1, 0, 5'h00, 1, 0);
    chk("t2_empty", {31'd0, empty}, 32'd1);

    // Fill, drop on full, then accept with a pop
    for (int i = 1; i <= 4; i++) step(1, 1, 5'(i), 0, 0);
    step(1, 1, 5'h05, 0, 0);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk("t3_count", {29'd0, count}, 32'd4);
    chk("t3_acc", {24'd0, acc}, 32'h34);
    step(1, 1, 5'h06, 1, 0);
    chk("t3b_count", {29'd0, count}, 32'd4);
    chk("t3b_acc", {24'd0, acc}, 32'h3A);
    chk("t3b_ovf", {31'd0, overflow}, 32'd1);
    step(1, 0, 5'h00, 1, 0);
    chk("t1_pre", {29'd0, count}, 32'd3);

    // Asynchronous reset mid-burst
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t1_count", {29'd0, count}, 32'd0);
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_data", {27'd0, out_data}, 32'd0);
    chk("t1_acc", {24'd0, acc}, 32'd0);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming pairs across pointer wrap
    for (int i = 0; i < 10; i++) step(1, 1, 5'(i), 1, 0);
    step(1, 0, 5'h00, 1, 0);
    chk("t4_acc45", {24'd0, acc}, 32'd45);
    chk("t4_empty", {31'd0, empty}, 32'd1);
    step(1, 0, 5'h00, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 5'h1F, 1, 0);
    step(1, 0, 5'h00, 1, 0);
    chk("t4_acc6c", {24'd0, acc}, 32'h6C);

    // Clear with coincident push, then with coincident drop
    for (int i = 0; i < 4; i++) step(1, 1, 5'(8'h11 + i), 0, 0);
    step(1, 1, 5'h15, 0, 0);
    chk("t5_ovf_set", {31'd0, overflow}, 32'd1);
    step(1, 1, 5'h07, 1, 1);
    chk("t5_acc7", {24'd0, acc}, 32'h07);
    chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);
    step(1, 1, 5'h09, 0, 1);
    chk("t5_acc0", {24'd0, acc}, 32'h00);
    chk("t5_ovf_win", {31'd0, overflow}, 32'd1);
    step(1, 1, 5'h05, 1, 0);

    // Freeze: every request ignored
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5'h1A, 1, 1);
      chk("t6_count", {29'd0, count}, 32'd4);
      chk("t6_acc", {24'd0, acc}, 32'h05);
      chk("t6_ovf", {31'd0, overflow}, 32'd1);
      chk("t6_head", {27'd0, out_data}, 32'h13);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 5'h00, 1, 0);
    chk("t6_drained", {31'd0, empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
